move_scheduler: RTL

Command-buffer and sequencer for the stepper motion datapath. Accepts move descriptors (direction, step count, step interval) from the SPI command decoder into a small FIFO. Executes the moves back-to-back by generating STEP/DIR pulses. Reports BUFFER_DTR (space available) and MOVE_DONE to the pads. HALT aborts the active move and flushes all queued moves.

---
 rtl/move_scheduler.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/move_scheduler.sv
// move_scheduler
//   Command buffer and sequencer for the stepper motion datapath. Move
//   descriptors (direction, step count, step interval) are queued in a small
//   FIFO and executed back-to-back as STEP/DIR pulse trains.
//
//   Ports:
//     CLK, resetn          clock, synchronous active-low reset
//     wr_valid/wr_dir/     move descriptor write (accepted when buffer_dtr=1)
//     wr_steps/wr_interval
//     halt                 level abort: kills active move, flushes the FIFO
//     step, dir            step pulse (1 CLK wide) and direction of active move
//     buffer_dtr           FIFO can accept a write this cycle
//     move_done            1-cycle pulse at the end of each move
//     busy                 sequencer not idle
//     steps_left           remaining steps of the active move
//     overflow             sticky: a write was dropped (full or halted)
module move_scheduler #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned STEP_W = 32,
    parameter int unsigned INTV_W = 32
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic              wr_valid,
    input  logic              wr_dir,
    input  logic [STEP_W-1:0] wr_steps,
    input  logic [INTV_W-1:0] wr_interval,
    input  logic              halt,
    output logic              step,
    output logic              dir,
    output logic              buffer_dtr,
    output logic              move_done,
    output logic              busy,
    output logic [STEP_W-1:0] steps_left,
    output logic              overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
    localparam logic [INTV_W-1:0] INTV_ONE = INTV_W'(1);
    localparam logic [INTV_W-1:0] INTV_MIN = INTV_W'(2);

    // FIFO storage (no reset needed; pointers/count define validity)
    logic              mem_dir_q   [DEPTH];
    logic [STEP_W-1:0] mem_steps_q [DEPTH];
    logic [INTV_W-1:0] mem_intv_q  [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              dir_q, dir_d;
    logic [STEP_W-1:0] steps_left_q, steps_left_d;
    logic [INTV_W-1:0] intv_q, intv_d;
    logic [INTV_W-1:0] tick_q, tick_d;
    logic              step_q, step_d;
    logic              move_done_q, move_done_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;

    logic              accept;
    logic              pop;
    logic              pulse;
    logic [INTV_W-1:0] head_intv;

    assign buffer_dtr = (count_q != CNT_FULL) & ~halt;
    assign accept     = wr_valid & buffer_dtr;
    assign pop        = (state_q == S_LOAD) & ~halt;
    assign pulse      = (state_q == S_RUN) && (tick_q == intv_q - INTV_ONE);
    assign head_intv  = mem_intv_q[rd_ptr_q];

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        dir_d        = dir_q;
        steps_left_d = steps_left_q;
        intv_d       = intv_q;
        tick_d       = tick_q;
        overflow_d   = overflow_q | (wr_valid & ~buffer_dtr);

        if (halt) begin
            state_d      = S_IDLE;
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            steps_left_d = '0;
            tick_d       = '0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            unique case ({accept, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase

            unique case (state_q)
                S_IDLE: begin
                    if (count_q != '0) state_d = S_LOAD;
                end
                S_LOAD: begin
                    rd_ptr_d     = rd_ptr_q + PTR_ONE;
                    dir_d        = mem_dir_q[rd_ptr_q];
                    steps_left_d = mem_steps_q[rd_ptr_q];
                    intv_d       = (head_intv < INTV_MIN) ? INTV_MIN : head_intv;
                    tick_d       = '0;
                    state_d      = (mem_steps_q[rd_ptr_q] == '0) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    if (pulse) begin
                        tick_d       = '0;
                        steps_left_d = steps_left_q - STEP_ONE;
                        if (steps_left_q == STEP_ONE) state_d = S_DONE;
                    end else begin
                        tick_d = tick_q + INTV_ONE;
                    end
                end
                S_DONE: begin
                    state_d = (count_q != '0) ? S_LOAD : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Registered outputs are derived from next state so they line up
        // with the cycle the state is actually in.
        step_d      = (state_d == S_RUN) && (tick_d == intv_d - INTV_ONE);
        move_done_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            dir_q        <= 1'b0;
            steps_left_q <= '0;
            intv_q       <= INTV_MIN;
            tick_q       <= '0;
            step_q       <= 1'b0;
            move_done_q  <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            dir_q        <= dir_d;
            steps_left_q <= steps_left_d;
            intv_q       <= intv_d;
            tick_q       <= tick_d;
            step_q       <= step_d;
            move_done_q  <= move_done_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (resetn && accept) begin
            mem_dir_q[wr_ptr_q]   <= wr_dir;
            mem_steps_q[wr_ptr_q] <= wr_steps;
            mem_intv_q[wr_ptr_q]  <= wr_interval;
        end
    end

    // Halt must kill a pulse in the very cycle it is raised.
    assign step       = step_q & ~halt;
    assign dir        = dir_q;
    assign move_done  = move_done_q;
    assign busy       = busy_q;
    assign steps_left = steps_left_q;
    assign overflow   = overflow_q;

endmodule
